unsigned_mul_nxn_ha_array_pipe: RTL and testbench

UNSIGNED_MUL_NXN_HA_ARRAY_PIPE -- requirements
Module: unsigned_mul_nxn_ha_array_pipe

---
 rtl/unsigned_mul_nxn_ha_array_pipe.sv | 136 +++++++++++++
 tb/tb_unsigned_mul_nxn_ha_array_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_mul_nxn_ha_array_pipe.sv
// Unsigned WIDTHxWIDTH multiplier built from paired-row half-adder arrays,
// with selectable approximation of the low product columns. It has a two-stage
// valid/ready pipeline: stage 1 holds the per-array t/b vectors, and stage 2
// holds the reduced product.
module unsigned_mul_nxn_ha_array_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned NARR = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        MODE_EXACT  = 2'd0,
        MODE_OR     = 2'd1,
        MODE_ACARRY = 2'd2,
        MODE_ELIM   = 2'd3
    } mode_e;

    logic                       s1_valid_q, s1_valid_d;
    logic                       out_valid_q, out_valid_d;
    logic [PW-1:0]              p_q, p_d;
    logic [NARR-1:0][WIDTH:0]   t_q, t_d;
    logic [NARR-1:0][WIDTH-2:0] b_q, b_d;

    logic                       s2_ready, accept, s2_load;
    logic [WIDTH-1:0]           row_a, row_b;
    logic                       sum_bit, carry_bit;
    int unsigned                col;
    mode_e                      mode_sel;
    logic [PW-1:0]              arr_val, p_sum;

    // Handshake: each stage advances when the stage after it is empty or draining
    always_comb begin
        s2_ready    = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || s2_ready;
        accept      = in_valid && in_ready;
        s2_load     = s1_valid_q && s2_ready;
        s1_valid_d  = accept || (s1_valid_q && !s2_ready);
        out_valid_d = s2_load || (out_valid_q && !out_ready);
    end

    // Half-adder arrays: array k pairs partial-product rows 2k (A) and 2k+1 (B)
    always_comb begin
        t_d       = '0;
        b_d       = '0;
        row_a     = '0;
        row_b     = '0;
        sum_bit   = 1'b0;
        carry_bit = 1'b0;
        col       = 0;
        mode_sel  = mode_e'(mode);
        for (int unsigned k = 0; k < NARR; k++) begin
            row_a = x[2*k]   ? y : '0;
            row_b = x[2*k+1] ? y : '0;
            t_d[k][0]       = row_a[0];
            b_d[k][WIDTH-2] = row_b[WIDTH-1];
            for (int unsigned j = 1; j < WIDTH; j++) begin
                col = 2*k + j;
                if (col >= APPROX_COLS || mode_sel == MODE_EXACT) begin
                    sum_bit   = row_a[j] ^ row_b[j-1];
                    carry_bit = row_a[j] & row_b[j-1];
                end else begin
                    case (mode_sel)
                        MODE_OR: begin
                            sum_bit   = row_a[j] | row_b[j-1];
                            carry_bit = 1'b0;
                        end
                        MODE_ACARRY: begin
                            sum_bit   = 1'b0;
                            carry_bit = row_a[j];
                        end
                        default: begin
                            sum_bit   = 1'b0;
                            carry_bit = 1'b0;
                        end
                    endcase
                end
                t_d[k][j] = sum_bit;
                // The top cell's carry lands at weight WIDTH, next to B[WIDTH-1] in b
                if (j == WIDTH-1) begin
                    t_d[k][WIDTH] = carry_bit;
                end else begin
                    b_d[k][j-1] = carry_bit;
                end
            end
        end
    end

    // Reduction: sum every array value, (t + (b << 2)) << 2k, modulo 2^PW
    always_comb begin
        p_sum   = '0;
        arr_val = '0;
        for (int unsigned k = 0; k < NARR; k++) begin
            arr_val = PW'(t_q[k]) + (PW'(b_q[k]) << 2);
            p_sum   = p_sum + (arr_val << (2*k));
        end
        p_d = s2_load ? p_sum : p_q;
    end

    // Control and product registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
        end
    end

    // Stage-1 datapath capture on accept; qualified by s1_valid_q so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            t_q <= t_d;
            b_q <= b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_unsigned_mul_nxn_ha_array_pipe.sv
// Self-checking bench for unsigned_mul_nxn_ha_array_pipe (WIDTH=8, APPROX_COLS=4).
module tb_unsigned_mul_nxn_ha_array_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned AC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] p;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unsigned_mul_nxn_ha_array_pipe #(
        .WIDTH       (W),
        .APPROX_COLS (AC)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    // Value-level model: every cell contributes (sum + 2*carry) at its column weight.
    function automatic logic [2*W-1:0] model(input int unsigned xv, input int unsigned yv,
                                             input int unsigned md);
        longint unsigned acc;
        int unsigned a, b, w, v;
        acc = 0;
        for (int unsigned k = 0; k < W/2; k++) begin
            acc += longint'(((xv >> (2*k)) & 1) & (yv & 1)) << (2*k);
            acc += longint'(((xv >> (2*k+1)) & 1) & ((yv >> (W-1)) & 1)) << (2*k+W);
            for (int unsigned j = 1; j < W; j++) begin
                a = ((xv >> (2*k)) & 1) & ((yv >> j) & 1);
                b = ((xv >> (2*k+1)) & 1) & ((yv >> (j-1)) & 1);
                w = 2*k + j;
                if (md == 0 || w >= AC) v = a + b;
                else if (md == 1)       v = a | b;
                else if (md == 2)       v = 2 * a;
                else                    v = 0;
                acc += longint'(v) << w;
            end
        end
        model = acc[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; mode = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
        checks++;
        if (p !== 16'd0) begin errors++; $display("FAIL reset_p: got %0d expected 0", p); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
    endtask

    task automatic test_max_product();
        in_valid = 1'b1; x = 8'd255; y = 8'd255; mode = 2'd0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL max_latency_early: got out_valid=%0d expected 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || p !== 16'd65025) begin
            errors++; $display("FAIL max_product: got valid=%0d p=%0d expected valid=1 p=65025", out_valid, p);
        end
        tick();
        tick();
    endtask

    task automatic test_modes();
        int exp_m [4] = '{9, 7, 5, 1};
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1; x = 8'd3; y = 8'd3; mode = 2'(m);
            tick();
            in_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || p !== 16'(exp_m[m])) begin
                errors++; $display("FAIL mode%0d_3x3: got valid=%0d p=%0d expected valid=1 p=%0d", m, out_valid, p, exp_m[m]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int xs [3] = '{1, 2, 15};
        int ys [3] = '{1, 3, 15};
        int ex [3] = '{1, 6, 225};
        out_ready = 1'b1; mode = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; x = 8'(xs[c]); y = 8'(ys[c]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || p !== 16'(ex[c-1])) begin
                    errors++; $display("FAIL b2b_%0d: got valid=%0d p=%0d expected valid=1 p=%0d", c-1, out_valid, p, ex[c-1]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        int xs [3] = '{7, 12, 200};
        int ys [3] = '{9, 11, 3};
        int ex [3] = '{63, 132, 600};
        int idx = 0;
        int nout = 0;
        bit have_ref = 0;
        logic [2*W-1:0] ref_p = '0;
        out_ready = 1'b0; mode = 2'd0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin x = 8'(xs[idx]); y = 8'(ys[idx]); end
            #1;
            if (out_valid) begin
                if (have_ref) begin
                    checks++;
                    if (p !== ref_p) begin errors++; $display("FAIL stall_p_stable: got %0d expected %0d", p, ref_p); end
                end else begin
                    ref_p = p; have_ref = 1;
                end
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        #1;
        checks++;
        if (idx != 2) begin errors++; $display("FAIL stall_accepted: got %0d expected 2", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0d expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || p !== 16'(ex[0])) begin
            errors++; $display("FAIL stall_head: got valid=%0d p=%0d expected valid=1 p=%0d", out_valid, p, ex[0]);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && nout < 3; cyc++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin x = 8'(xs[idx]); y = 8'(ys[idx]); end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (p !== 16'(ex[nout])) begin errors++; $display("FAIL release_%0d: got %0d expected %0d", nout, p, ex[nout]); end
                nout++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (nout != 3) begin errors++; $display("FAIL release_count: got %0d expected 3", nout); end
        tick();
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0; mode = 2'd0;
        in_valid = 1'b1; x = 8'd5; y = 8'd5;
        tick();
        x = 8'd6; y = 8'd6;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstflight_out_valid: got %0d expected 0", out_valid); end
        checks++;
        if (p !== 16'd0) begin errors++; $display("FAIL rstflight_p: got %0d expected 0", p); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstflight_in_ready: got %0d expected 1", in_ready); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstflight_stale_%0d: got out_valid=%0d expected 0", cyc, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] q [$];
        logic [2*W-1:0] exp_p;
        logic [2*W-1:0] prev_p = '0;
        bit prev_hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: x = 8'hFF;
                1: x = 8'h00;
                default: x = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: y = 8'hFF;
                1: y = 8'h00;
                default: y = 8'($urandom);
            endcase
            mode = 2'($urandom_range(0, 3));
            #1;
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || p !== prev_p) begin
                    errors++; $display("FAIL rand_hold: got valid=%0d p=%0d expected valid=1 p=%0d", out_valid, p, prev_p);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got p=%0d expected no output", p);
                end else begin
                    exp_p = q.pop_front();
                    if (p !== exp_p) begin errors++; $display("FAIL rand_p: got %0d expected %0d", p, exp_p); end
                end
            end
            if (in_valid && in_ready) q.push_back(model(x, y, mode));
            prev_hold = out_valid && !out_ready;
            prev_p    = p;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
            #1;
            if (out_valid) begin
                checks++;
                exp_p = q.pop_front();
                if (p !== exp_p) begin errors++; $display("FAIL drain_p: got %0d expected %0d", p, exp_p); end
            end
            tick();
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain_left: got %0d expected 0", q.size()); end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle: got out_valid=%0d expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_max_product();
        test_modes();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
